// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 PIPE control slice.
// Holds the instruction codes, the status codes, the RNONE register ID,
// the processor-status FSM state type and the default condition-code reset value.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // "No register" ID
    localparam logic [3:0] RNONE = 4'hF;

    // Default condition codes {ZF,SF,OF}: zero flag set
    localparam logic [2:0] CC_RESET_DEFAULT = 3'b100;

    // Processor status state machine
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STOPPED = 1'b1
    } cpu_state_e;

    // Any status other than AOK is an exception.
    function automatic logic is_exc(input logic [2:0] stat);
        return stat != STAT_AOK;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clock    - system clock
//   reset_n  - asynchronous active-low reset, clears the count
//   inc      - increment request for this cycle
//   count    - current count; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the five-stage Y86-64 PIPE processor.
// Detects load/use, return and mispredict hazards and drives the stall/bubble
// controls of the F, D, E, M and W pipeline registers. Owns the condition-code
// register, the processor-status FSM (RUN/STOPPED) and two saturating
// performance counters.
// Ports:
//   clock, reset_n                - clock, asynchronous active-low reset
//   D_icode, d_srcA, d_srcB       - decode-stage icode and source register IDs
//   E_icode, E_dstM, e_Cnd, e_cc  - execute-stage icode, load destination,
//                                   branch condition and ALU flags
//   M_icode, m_stat               - memory-stage icode and status
//   W_stat                        - writeback-register status
//   F_stall, D_stall, W_stall     - hold the register at the next edge
//   D_bubble, E_bubble, M_bubble  - insert a bubble at the next edge
//   set_cc                        - condition codes load e_cc at the next edge
//   cc                            - current {ZF,SF,OF}
//   cpu_stat, halted              - processor status, high while STOPPED
//   stall_cnt, mispred_cnt        - fetch-stall and mispredict counters
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter logic [2:0]  CC_RESET = CC_RESET_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [2:0]       e_cc,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic [2:0]       cc,
    output logic [2:0]       cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    cpu_state_e state_q, state_d;
    logic [2:0] cc_q, cc_d;
    logic [2:0] cpu_stat_q, cpu_stat_d;

    logic loaduse, retpend, mispred, exc_m, exc_w;
    logic stall_inc, mispred_inc;

    always_comb begin
        loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                  (E_dstM != RNONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        retpend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispred = (E_icode == I_JXX) && !e_Cnd;
        exc_m   = is_exc(m_stat);
        exc_w   = is_exc(W_stat);

        F_stall    = 1'b0;
        D_stall    = 1'b0;
        W_stall    = 1'b0;
        D_bubble   = 1'b0;
        E_bubble   = 1'b0;
        M_bubble   = 1'b0;
        set_cc     = 1'b0;
        state_d    = state_q;
        cpu_stat_d = cpu_stat_q;
        cc_d       = cc_q;

        if (state_q == ST_RUN) begin
            F_stall  = loaduse | retpend;
            D_stall  = loaduse;
            // Load/use wins over a pending RET so D is never stalled and bubbled at once.
            D_bubble = mispred | (retpend & ~loaduse);
            E_bubble = mispred | loaduse;
            M_bubble = exc_m | exc_w;
            W_stall  = exc_w;
            set_cc   = (E_icode == I_OPQ) & ~exc_m & ~exc_w;
            if (exc_w) begin
                state_d    = ST_STOPPED;
                cpu_stat_d = W_stat;
            end
        end else begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            W_stall = 1'b1;
        end

        if (set_cc) begin
            cc_d = e_cc;
        end

        // Counters only advance while running; STOPPED's forced stalls are not counted.
        stall_inc   = (state_q == ST_RUN) && F_stall;
        mispred_inc = (state_q == ST_RUN) && mispred;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            cc_q       <= CC_RESET;
            cpu_stat_q <= STAT_AOK;
        end else begin
            state_q    <= state_d;
            cc_q       <= cc_d;
            cpu_stat_q <= cpu_stat_d;
        end
    end

    assign cc       = cc_q;
    assign cpu_stat = cpu_stat_q;
    assign halted   = (state_q == ST_STOPPED);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .count   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (mispred_inc),
        .count   (mispred_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard cases, randomized traffic
// and a long mispredict run, scored against a reference model through a queue.
module tb_pipe_ctrl;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [3:0] d_icode, d_srca, d_srcb, e_icode, e_dstm, m_icode;
        logic       e_cnd;
        logic [2:0] e_cc, m_stat, w_stat;
        logic       rst_n;
    } stim_t;

    typedef struct {
        logic        f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, set_cc;
        logic [2:0]  cc, cpu_stat;
        logic        halted;
        int          stall_cnt, mispred_cnt;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic             e_Cnd;
    logic [2:0]       e_cc, m_stat, W_stat;
    logic             F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc;
    logic [2:0]       cc, cpu_stat;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt, mispred_cnt;

    pipe_ctrl #(.CNT_W(CNT_W), .CC_RESET(3'b100)) dut (
        .clock(clock), .reset_n(reset_n),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .e_cc(e_cc),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .set_cc(set_cc), .cc(cc), .cpu_stat(cpu_stat), .halted(halted),
        .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clock = ~clock;

    // Reference model state
    bit         mdl_stopped = 1'b0;
    logic [2:0] mdl_cc      = 3'b100;
    logic [2:0] mdl_stat    = 3'd1;
    int         mdl_stalls  = 0;
    int         mdl_mispred = 0;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    endtask

    // Monitor: pops one expectation per cycle and compares all outputs.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("F_stall",     int'(F_stall),     int'(e.f_stall));
            chk("D_stall",     int'(D_stall),     int'(e.d_stall));
            chk("W_stall",     int'(W_stall),     int'(e.w_stall));
            chk("D_bubble",    int'(D_bubble),    int'(e.d_bubble));
            chk("E_bubble",    int'(E_bubble),    int'(e.e_bubble));
            chk("M_bubble",    int'(M_bubble),    int'(e.m_bubble));
            chk("set_cc",      int'(set_cc),      int'(e.set_cc));
            chk("cc",          int'(cc),          int'(e.cc));
            chk("cpu_stat",    int'(cpu_stat),    int'(e.cpu_stat));
            chk("halted",      int'(halted),      int'(e.halted));
            chk("stall_cnt",   int'(stall_cnt),   e.stall_cnt);
            chk("mispred_cnt", int'(mispred_cnt), e.mispred_cnt);
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s.d_icode = 4'h1; s.e_icode = 4'h1; s.m_icode = 4'h1;
        s.d_srca = 4'hF; s.d_srcb = 4'hF; s.e_dstm = 4'hF;
        s.e_cnd = 1'b1; s.e_cc = 3'b000;
        s.m_stat = 3'd1; s.w_stat = 3'd1;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.d_icode = 4'($urandom_range(0, 11));
        s.e_icode = 4'($urandom_range(0, 11));
        s.m_icode = 4'($urandom_range(0, 11));
        s.d_srca  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
        s.d_srcb  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
        s.e_dstm  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
        s.e_cnd   = 1'($urandom_range(0, 1));
        s.e_cc    = 3'($urandom_range(0, 7));
        s.m_stat  = ($urandom_range(0, 7) == 0)  ? 3'($urandom_range(0, 7)) : 3'd1;
        s.w_stat  = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
        s.rst_n   = ($urandom_range(0, 59) != 0);
        return s;
    endfunction

    // Apply one cycle of stimulus away from the edge, queue the expectation,
    // then advance the model across the coming edge.
    task automatic step(input stim_t s);
        exp_t e;
        bit   ld_use, ret_pend, mis, exc_m, exc_w, upd_cc;
        @(posedge clock);
        #1;
        reset_n = s.rst_n;
        D_icode = s.d_icode; d_srcA = s.d_srca; d_srcB = s.d_srcb;
        E_icode = s.e_icode; E_dstM = s.e_dstm; e_Cnd = s.e_cnd; e_cc = s.e_cc;
        M_icode = s.m_icode; m_stat = s.m_stat; W_stat = s.w_stat;

        if (!s.rst_n) begin
            mdl_stopped = 1'b0; mdl_cc = 3'b100; mdl_stat = 3'd1;
            mdl_stalls = 0; mdl_mispred = 0;
        end

        ld_use   = (s.e_icode inside {4'h5, 4'hB}) && s.e_dstm != 4'hF &&
                   (s.e_dstm == s.d_srca || s.e_dstm == s.d_srcb);
        ret_pend = (s.d_icode == 4'h9) || (s.e_icode == 4'h9) || (s.m_icode == 4'h9);
        mis      = (s.e_icode == 4'h7) && !s.e_cnd;
        exc_m    = s.m_stat != 3'd1;
        exc_w    = s.w_stat != 3'd1;

        if (mdl_stopped) begin
            e.f_stall = 1; e.d_stall = 1; e.w_stall = 1;
            e.d_bubble = 0; e.e_bubble = 0; e.m_bubble = 0; e.set_cc = 0;
        end else begin
            e.f_stall  = ld_use || ret_pend;
            e.d_stall  = ld_use;
            e.w_stall  = exc_w;
            e.d_bubble = mis || (ret_pend && !ld_use);
            e.e_bubble = mis || ld_use;
            e.m_bubble = exc_m || exc_w;
            e.set_cc   = (s.e_icode == 4'h6) && !exc_m && !exc_w;
        end
        e.cc          = mdl_cc;
        e.cpu_stat    = mdl_stat;
        e.halted      = mdl_stopped;
        e.stall_cnt   = mdl_stalls;
        e.mispred_cnt = mdl_mispred;
        exp_q.push_back(e);

        upd_cc = e.set_cc;
        if (s.rst_n && !mdl_stopped) begin
            if (e.f_stall) mdl_stalls  = (mdl_stalls  < CNT_MAX) ? mdl_stalls  + 1 : CNT_MAX;
            if (mis)       mdl_mispred = (mdl_mispred < CNT_MAX) ? mdl_mispred + 1 : CNT_MAX;
            if (upd_cc)    mdl_cc = s.e_cc;
            if (exc_w) begin
                mdl_stopped = 1'b1;
                mdl_stat    = s.w_stat;
            end
        end
    endtask

    initial begin
        stim_t s;
        reset_n = 1'b0;
        D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1; E_dstM = 4'hF;
        e_Cnd = 1'b1; e_cc = 3'b000; M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1;

        s = idle(); s.rst_n = 1'b0;
        step(s); step(s);
        step(idle());

        // Load/use on rA
        s = idle(); s.e_icode = 4'h5; s.e_dstm = 4'd3; s.d_srca = 4'd3; step(s);
        // Load/use on rB via POPQ
        s = idle(); s.e_icode = 4'hB; s.e_dstm = 4'd2; s.d_srcb = 4'd2; step(s);
        // Mispredict
        s = idle(); s.e_icode = 4'h7; s.e_cnd = 1'b0; step(s);
        // RET advancing D -> E -> M
        s = idle(); s.d_icode = 4'h9; step(s);
        s = idle(); s.e_icode = 4'h9; step(s);
        s = idle(); s.m_icode = 4'h9; step(s);
        // Load/use together with pending RET
        s = idle(); s.e_icode = 4'h5; s.e_dstm = 4'd1; s.d_srca = 4'd1; s.m_icode = 4'h9; step(s);
        // OPQ updates CC; then OPQ with m_stat=ADR must not
        s = idle(); s.e_icode = 4'h6; s.e_cc = 3'b010; step(s);
        s = idle(); s.e_icode = 4'h6; s.e_cc = 3'b111; s.m_stat = 3'd3; step(s);
        step(idle());
        // excW with OPQ in the same cycle: halt, CC unchanged
        s = idle(); s.e_icode = 4'h6; s.e_cc = 3'b001; s.w_stat = 3'd2; step(s);
        s = idle(); s.e_icode = 4'h7; s.e_cnd = 1'b0; s.d_icode = 4'h9; step(s);
        step(idle()); step(idle());
        // Reset out of STOPPED
        s = idle(); s.rst_n = 1'b0; s.e_icode = 4'h7; s.e_cnd = 1'b0; step(s);
        step(idle());

        // Randomized traffic
        for (int i = 0; i < 3000; i++) step(rand_stim());

        // Long mispredict run to saturate the counter
        s = idle(); s.rst_n = 1'b0; step(s);
        s = idle(); s.e_icode = 4'h7; s.e_cnd = 1'b0;
        for (int i = 0; i < CNT_MAX + 1 + 5; i++) step(s);
        step(idle());
        step(idle());

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #2;
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 PIPE processor. It detects load/use, return and branch-mispredict hazards and drives the stall/bubble controls of the F, D, E, M and W pipeline registers. It owns the architectural condition-code register fed by the execute-stage ALU and gates its update on downstream exceptions. It also runs the processor status state machine and two saturating performance counters.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters
- CC_RESET, 3'b100, condition-code reset value as {ZF,SF,OF}

Ports:
- clock  in  1  system clock, all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- D_icode  in  4  icode held in the decode pipeline register
- d_srcA, d_srcB  in  4 each  decode-stage source register IDs; 4'hF is RNONE
- E_icode  in  4  icode in the execute register
- E_dstM  in  4  memory-destination register ID in the execute register
- e_Cnd  in  1  branch condition from execute-stage condition logic
- e_cc  in  3  {ZF,SF,OF} produced by the ALU this cycle
- M_icode  in  4  icode in the memory register
- m_stat  in  3  status produced by the memory stage
- W_stat  in  3  status in the writeback register
- F_stall, D_stall, W_stall  out  1 each  hold the register at next edge
- D_bubble, E_bubble, M_bubble  out  1 each  load the bubble value at next edge
- set_cc  out  1  CC register updates at next edge
- cc  out  3  current {ZF,SF,OF}
- cpu_stat  out  3  processor status (AOK/HLT/ADR/INS)
- halted  out  1  high in state STOPPED
- stall_cnt, mispred_cnt  out  CNT_W each  performance counters

## Operation
- Icodes: HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B. Stat: AOK 1, HLT 2, ADR 3, INS 4. A stat is exceptional when it is not AOK.
- loaduse = E_icode in {MRMOVQ,POPQ} and E_dstM != RNONE and E_dstM equals d_srcA or d_srcB.
- retpend = RET in any of D_icode, E_icode or M_icode.
- mispred = E_icode==JXX and !e_Cnd.
- excM = m_stat exceptional. excW = W_stat exceptional.
- State RUN:
  - F_stall = loaduse | retpend
  - D_stall = loaduse
  - D_bubble = mispred | (retpend & !loaduse)
  - E_bubble = mispred | loaduse
  - M_bubble = excM | excW
  - W_stall = excW
  - set_cc = E_icode==OPQ & !excM & !excW
- D_stall and D_bubble are never both high.
- FSM states are RUN and STOPPED.
  - RUN→STOPPED when excW.
  - STOPPED holds until reset.
- In STOPPED:
  - F_stall, D_stall and W_stall are 1.
  - All bubbles and set_cc are 0.
  - cpu_stat holds the W_stat captured on entry.
- cc loads e_cc on an edge with set_cc=1. Otherwise it holds.
- stall_cnt increments on each RUN cycle with F_stall=1. mispred_cnt increments on each RUN cycle with mispred=1.
- Both counters saturate at all-ones and do not wrap.

## Timing
- Stall, bubble and set_cc outputs are combinational from the current-cycle inputs and state, with zero latency. They take effect at the next posedge.
- cc, cpu_stat, halted and the counters are registered and change only at posedge.
- Reset values (async on reset_n=0):
  - state RUN
  - cc = CC_RESET
  - cpu_stat = AOK
  - halted = 0
  - counters = 0
- Reset asserted mid-stall or while STOPPED returns to RUN immediately. Combinational outputs then follow the inputs.
- If excW and a set_cc condition occur in the same cycle, excW wins: cc is unchanged.
- Counter saturation: at value 2^CNT_W−1, a further increment holds the value.

## Structure
- Shared package y86_pkg holds:
  - icode constants
  - stat codes
  - RNONE
  - the FSM state enumeration
  - default CC_RESET
- One sub-module, sat_counter (parameter W; ports clock, reset_n, inc, count), is instantiated twice.
- Hazard equations stay inline.

## Test plan
- E_icode=MRMOVQ, E_dstM=3, d_srcA=3 → F_stall=D_stall=E_bubble=1, D_bubble=0. stall_cnt +1.
- E_icode=JXX, e_Cnd=0, no RET → D_bubble=E_bubble=1, F_stall=0. mispred_cnt +1.
- RET in D_icode, no load/use → F_stall=1, D_bubble=1 for each of the 3 cycles RET advances D→E→M.
- E_icode=OPQ, e_cc=3'b010, stats AOK → cc=3'b010 after the edge. Same case with m_stat=ADR → cc unchanged, M_bubble=1.
- W_stat=HLT for one cycle → next edge halted=1, cpu_stat=HLT, F/D/W stall held. Pulse reset_n low → cc=3'b100, counters 0, halted=0.
- Drive mispred for 2^CNT_W+5 cycles → mispred_cnt=16'hFFFF and stays there.
